// File: rtl/axil_mem_arbiter_if.sv
// axil_mem_arbiter_if: write/read request channels plus the shared SRAM port
// seen by the memory arbiter.
interface axil_mem_arbiter_if #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 64,
    parameter int MEM_ADDR_RANGE = 5
);
    logic                      mem_w_req;
    logic                      mem_w_ack;
    logic                      mem_w_err;
    logic [ADDR_W-1:0]         mem_w_addr;
    logic [DATA_W-1:0]         mem_w_data;
    logic [DATA_W/8-1:0]       mem_w_strb;
    logic                      mem_r_req;
    logic                      mem_r_ack;
    logic                      mem_r_err;
    logic [ADDR_W-1:0]         mem_r_addr;
    logic [DATA_W-1:0]         mem_r_data;
    logic                      sram_en;
    logic                      sram_we;
    logic [MEM_ADDR_RANGE-1:0] sram_addr;
    logic [DATA_W-1:0]         sram_wdata;
    logic [DATA_W/8-1:0]       sram_wstrb;
    logic [DATA_W-1:0]         sram_rdata;

    modport slave (
        input  mem_w_req, mem_w_addr, mem_w_data, mem_w_strb, mem_r_req, mem_r_addr, sram_rdata,
        output mem_w_ack, mem_w_err, mem_r_ack, mem_r_err, mem_r_data,
               sram_en, sram_we, sram_addr, sram_wdata, sram_wstrb
    );
    modport master (
        output mem_w_req, mem_w_addr, mem_w_data, mem_w_strb, mem_r_req, mem_r_addr, sram_rdata,
        input  mem_w_ack, mem_w_err, mem_r_ack, mem_r_err, mem_r_data,
               sram_en, sram_we, sram_addr, sram_wdata, sram_wstrb
    );
endinterface

// File: rtl/axil_mem_arbiter.sv
// axil_mem_arbiter: round-robin sharing of one single-port SRAM between the
// write and read channels, with window check and level-held acks.
module axil_mem_arbiter #(
    parameter int                ADDR_W         = 32,
    parameter int                DATA_W         = 64,
    parameter logic [ADDR_W-1:0] MEM_ADDR_START = 'h1000_0000,
    parameter int                MEM_ADDR_RANGE = 5,
    parameter int                RD_LAT         = 1
) (
    input logic               aclk,
    input logic               aresetn,
    axil_mem_arbiter_if.slave bus
);
    localparam int SW = DATA_W / 8;
    localparam int BW = $clog2(SW);

    typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, W_HOLD, R_HOLD} state_t;

    state_t                    state_q, state_d;
    logic                      last_gnt_q, last_gnt_d;
    logic                      inwin_q, inwin_d;
    logic [1:0]                cnt_q, cnt_d;
    logic [MEM_ADDR_RANGE-1:0] addr_q, addr_d;
    logic [DATA_W-1:0]         wdata_q, wdata_d, rdata_q, rdata_d;
    logic [SW-1:0]             wstrb_q, wstrb_d;
    logic                      gnt_w, gnt_r;
    logic [ADDR_W-1:0]         req_addr, off;

    always_comb begin
        gnt_w      = state_q == IDLE && bus.mem_w_req && (!bus.mem_r_req || last_gnt_q);
        gnt_r      = state_q == IDLE && bus.mem_r_req && !gnt_w;
        req_addr   = gnt_w ? bus.mem_w_addr : bus.mem_r_addr;
        off        = req_addr - MEM_ADDR_START;
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        inwin_d    = inwin_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        if (gnt_w || gnt_r) begin
            state_d    = gnt_w ? WR : RD;
            last_gnt_d = gnt_r;
            inwin_d    = req_addr >= MEM_ADDR_START && (off >> (BW + MEM_ADDR_RANGE)) == '0;
            addr_d     = off[BW +: MEM_ADDR_RANGE];
        end
        if (gnt_w) begin
            wdata_d = bus.mem_w_data;
            wstrb_d = bus.mem_w_strb;
        end
        case (state_q)
            WR:      state_d = W_HOLD;
            RD: begin
                state_d = RD_WAIT;
                cnt_d   = 2'(RD_LAT - 1);
            end
            RD_WAIT: begin
                // Capture on the cycle the SRAM presents data; out-of-window reads return zero.
                if (cnt_q == 2'd0) begin
                    state_d = R_HOLD;
                    rdata_d = inwin_q ? bus.sram_rdata : '0;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            W_HOLD:  state_d = bus.mem_w_req ? W_HOLD : IDLE;
            R_HOLD:  state_d = bus.mem_r_req ? R_HOLD : IDLE;
            default: ;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            last_gnt_q <= 1'b1;
            inwin_q    <= 1'b0;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            inwin_q    <= inwin_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rdata_q    <= rdata_d;
        end
    end

    assign bus.mem_w_ack  = state_q == W_HOLD;
    assign bus.mem_w_err  = state_q == W_HOLD && !inwin_q;
    assign bus.mem_r_ack  = state_q == R_HOLD;
    assign bus.mem_r_err  = state_q == R_HOLD && !inwin_q;
    assign bus.mem_r_data = rdata_q;
    assign bus.sram_en    = (state_q == WR || state_q == RD) && inwin_q;
    assign bus.sram_we    = state_q == WR;
    assign bus.sram_addr  = addr_q;
    assign bus.sram_wdata = wdata_q;
    assign bus.sram_wstrb = wstrb_q;
endmodule

// File: tb/tb_axil_mem_arbiter.sv
// tb_axil_mem_arbiter: two arbiters (RD_LAT=1 and RD_LAT=3) with SRAM models,
// checked against a byte-level memory model and the grant-order rules.
module tb_axil_mem_arbiter;
    localparam int AW = 32, DW = 64, RANGE = 5, SW = 8, DEPTH = 32;
    localparam logic [AW-1:0] START = 32'h1000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             w_req[2], r_req[2];
    logic [AW-1:0]    w_addr[2], r_addr[2];
    logic [DW-1:0]    w_data[2];
    logic [SW-1:0]    w_strb[2];
    logic             w_ack[2], w_err[2], r_ack[2], r_err[2], en[2], we[2];
    logic [DW-1:0]    r_data[2], swdata[2];
    logic [RANGE-1:0] saddr[2];
    logic [SW-1:0]    swstrb[2];
    logic [DW-1:0]    ref_mem[2][DEPTH];
    int               pass_n = 0, tot_n = 0;
    bit               mon_on = 1'b0;
    bit               gq[$];

    for (genvar g = 0; g < 2; g++) begin : u
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [DW-1:0] mem[DEPTH];
        logic [DW-1:0] pipe[LAT];
        axil_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .MEM_ADDR_RANGE(RANGE)) bus ();
        axil_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_ADDR_START(START),
                           .MEM_ADDR_RANGE(RANGE), .RD_LAT(LAT)) dut (
            .aclk(clk), .aresetn(rst_n), .bus(bus.slave));
        assign bus.mem_w_req  = w_req[g];
        assign bus.mem_w_addr = w_addr[g];
        assign bus.mem_w_data = w_data[g];
        assign bus.mem_w_strb = w_strb[g];
        assign bus.mem_r_req  = r_req[g];
        assign bus.mem_r_addr = r_addr[g];
        assign bus.sram_rdata = pipe[LAT-1];
        assign w_ack[g]  = bus.mem_w_ack;
        assign w_err[g]  = bus.mem_w_err;
        assign r_ack[g]  = bus.mem_r_ack;
        assign r_err[g]  = bus.mem_r_err;
        assign r_data[g] = bus.mem_r_data;
        assign en[g]     = bus.sram_en;
        assign we[g]     = bus.sram_we;
        assign saddr[g]  = bus.sram_addr;
        assign swdata[g] = bus.sram_wdata;
        assign swstrb[g] = bus.sram_wstrb;
        always @(posedge clk) begin
            if (bus.sram_en && bus.sram_we)
                for (int b = 0; b < SW; b++)
                    if (bus.sram_wstrb[b]) mem[bus.sram_addr][8*b +: 8] <= bus.sram_wdata[8*b +: 8];
            pipe[0] <= (bus.sram_en && !bus.sram_we) ? mem[bus.sram_addr] : 'x;
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    always @(negedge clk) if (mon_on && en[1]) gq.push_back(we[1]);

    function automatic bit in_win(input logic [AW-1:0] a);
        return a >= START && (a - START) < 32'(DEPTH * SW);
    endfunction

    function automatic int widx(input logic [AW-1:0] a);
        return int'((a - START) / SW);
    endfunction

    function automatic logic [DW-1:0] exp_rd(input int k, input logic [AW-1:0] a);
        return in_win(a) ? ref_mem[k][widx(a)] : '0;
    endfunction

    task automatic do_write(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s, output int lat, output int ens,
                            output logic err, output logic clr, output logic [RANGE-1:0] sa);
        @(negedge clk);
        w_req[k] = 1'b1; w_addr[k] = a; w_data[k] = d; w_strb[k] = s;
        lat = -1; ens = 0; err = 1'bx; sa = '0;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            @(negedge clk);
            if (en[k]) begin ens++; sa = saddr[k]; end
            if (w_ack[k]) begin lat = i; err = w_err[k]; end
        end
        w_req[k] = 1'b0;
        @(negedge clk);
        clr = w_ack[k] | w_err[k];
        if (in_win(a))
            for (int b = 0; b < SW; b++) if (s[b]) ref_mem[k][widx(a)][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic do_read(input int k, input logic [AW-1:0] a, output int lat, output int ens,
                           output logic err, output logic clr, output logic [DW-1:0] data);
        @(negedge clk);
        r_req[k] = 1'b1; r_addr[k] = a;
        lat = -1; ens = 0; err = 1'bx; data = 'x;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            @(negedge clk);
            if (en[k]) ens++;
            if (r_ack[k]) begin lat = i; err = r_err[k]; data = r_data[k]; end
        end
        r_req[k] = 1'b0;
        @(negedge clk);
        clr = r_ack[k] | r_err[k];
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            tot_n++;
            if ({w_ack[k], w_err[k], r_ack[k], r_err[k], en[k], we[k], r_data[k], saddr[k], swdata[k], swstrb[k]} !== '0)
                $display("FAIL reset_k%0d outputs got %h exp 0", k,
                         {w_ack[k], w_err[k], r_ack[k], r_err[k], en[k], we[k], r_data[k], saddr[k], swdata[k], swstrb[k]});
            else pass_n++;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fill;
        int lat, ens; logic err, clr; logic [RANGE-1:0] sa;
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < DEPTH; i++)
                do_write(k, START + AW'(8 * i), {$urandom, $urandom}, 8'hFF, lat, ens, err, clr, sa);
    endtask

    task automatic test_single_write;
        int lat, ens; logic err, clr; logic [RANGE-1:0] sa;
        for (int k = 0; k < 2; k++) begin
            do_write(k, 32'h1000_0008, 64'hDEAD_BEEF_0123_4567, 8'hFF, lat, ens, err, clr, sa);
            tot_n++; if (lat !== 1) $display("FAIL wr_lat_k%0d got %0d exp 1", k, lat); else pass_n++;
            tot_n++; if (ens !== 1) $display("FAIL wr_en_pulses_k%0d got %0d exp 1", k, ens); else pass_n++;
            tot_n++; if (sa !== 5'd1) $display("FAIL wr_sram_addr_k%0d got %0d exp 1", k, sa); else pass_n++;
            tot_n++; if (err !== 1'b0) $display("FAIL wr_err_k%0d got %b exp 0", k, err); else pass_n++;
            tot_n++; if (clr !== 1'b0) $display("FAIL wr_ack_clear_k%0d got %b exp 0", k, clr); else pass_n++;
        end
    endtask

    task automatic test_readback;
        int lat, ens; logic err, clr; logic [DW-1:0] d;
        for (int k = 0; k < 2; k++) begin
            do_read(k, 32'h1000_0008, lat, ens, err, clr, d);
            tot_n++; if (lat !== (k ? 4 : 2)) $display("FAIL rd_lat_k%0d got %0d exp %0d", k, lat, k ? 4 : 2); else pass_n++;
            tot_n++; if (d !== 64'hDEAD_BEEF_0123_4567) $display("FAIL rd_data_k%0d got %h exp deadbeef01234567", k, d); else pass_n++;
            tot_n++; if ({ens, err, clr} !== {32'd1, 2'b00}) $display("FAIL rd_en_err_clr_k%0d got %0d/%b/%b exp 1/0/0", k, ens, err, clr); else pass_n++;
        end
    endtask

    task automatic test_oob;
        int lat, ens; logic err, clr; logic [DW-1:0] d; logic [RANGE-1:0] sa;
        do_read(1, 32'h1000_0008, lat, ens, err, clr, d);
        do_write(1, 32'h0FFF_FFF8, 64'h1111_2222_3333_4444, 8'hFF, lat, ens, err, clr, sa);
        tot_n++; if ({lat, ens, err, clr} !== {32'd1, 32'd0, 2'b10}) $display("FAIL oob_wr lat/en/err/clr got %0d/%0d/%b/%b exp 1/0/1/0", lat, ens, err, clr); else pass_n++;
        do_read(1, 32'h1000_0100, lat, ens, err, clr, d);
        tot_n++; if ({lat, ens, err, clr} !== {32'd4, 32'd0, 2'b10}) $display("FAIL oob_rd lat/en/err/clr got %0d/%0d/%b/%b exp 4/0/1/0", lat, ens, err, clr); else pass_n++;
        tot_n++; if (d !== '0) $display("FAIL oob_rd_data got %h exp 0", d); else pass_n++;
        do_read(1, 32'h1000_00FF, lat, ens, err, clr, d);
        tot_n++; if ({ens, err} !== {32'd1, 1'b0}) $display("FAIL last_word en/err got %0d/%b exp 1/0", ens, err); else pass_n++;
        tot_n++; if (d !== ref_mem[1][31]) $display("FAIL last_word_data got %h exp %h", d, ref_mem[1][31]); else pass_n++;
    endtask

    task automatic test_strobe;
        int lat, ens; logic err, clr; logic [DW-1:0] d; logic [RANGE-1:0] sa;
        logic [DW-1:0] a = {$urandom, $urandom}, b = {$urandom, $urandom};
        do_write(1, 32'h1000_0010, a, 8'hFF, lat, ens, err, clr, sa);
        do_write(1, 32'h1000_0010, b, 8'h0F, lat, ens, err, clr, sa);
        do_write(1, 32'h1000_0010, ~a, 8'h00, lat, ens, err, clr, sa);
        tot_n++; if ({ens, sa} !== {32'd1, 5'd2}) $display("FAIL zero_strb en/addr got %0d/%0d exp 1/2", ens, sa); else pass_n++;
        do_read(1, 32'h1000_0013, lat, ens, err, clr, d);
        tot_n++; if (d !== {a[63:32], b[31:0]}) $display("FAIL strobe_merge got %h exp %h", d, {a[63:32], b[31:0]}); else pass_n++;
        tot_n++; if (d !== exp_rd(1, 32'h1000_0013)) $display("FAIL strobe_model got %h exp %h", d, exp_rd(1, 32'h1000_0013)); else pass_n++;
    endtask

    task automatic test_early_drop;
        int acks = 0, lat, ens; logic err, clr; logic [DW-1:0] d, v = {$urandom, $urandom};
        @(negedge clk);
        w_req[0] = 1'b1; w_addr[0] = 32'h1000_0018; w_data[0] = v; w_strb[0] = 8'hFF;
        @(negedge clk);
        w_req[0] = 1'b0;
        repeat (6) begin @(negedge clk); if (w_ack[0]) acks++; end
        ref_mem[0][3] = v;
        tot_n++; if (acks !== 1) $display("FAIL early_drop_ack_cycles got %0d exp 1", acks); else pass_n++;
        do_read(0, 32'h1000_0018, lat, ens, err, clr, d);
        tot_n++; if (d !== v) $display("FAIL early_drop_data got %h exp %h", d, v); else pass_n++;
    endtask

    task automatic test_tie;
        logic [15:0] got = '0;
        int bad = 0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        gq.delete();
        mon_on = 1'b1;
        for (int r = 0; r < 4; r++) begin
            fork
                if (r != 1) begin
                    int n = (r == 3) ? 3 : 1;
                    repeat (n) begin
                        int lat, ens; logic err, clr; logic [DW-1:0] d;
                        do_read(1, START, lat, ens, err, clr, d);
                        if (d !== ref_mem[1][0]) bad++;
                    end
                end
                begin
                    int n = (r == 3) ? 3 : 1;
                    repeat (n) begin
                        int lat, ens; logic err, clr; logic [RANGE-1:0] sa;
                        do_write(1, START + 32'h28, {$urandom, $urandom}, 8'hFF, lat, ens, err, clr, sa);
                    end
                end
            join
        end
        mon_on = 1'b0;
        foreach (gq[i]) got = {got[14:0], gq[i]};
        tot_n++; if (gq.size() !== 11) $display("FAIL tie_grant_count got %0d exp 11", gq.size()); else pass_n++;
        tot_n++; if (got !== 16'h0555) $display("FAIL tie_grant_order got %h exp 0555", got); else pass_n++;
        tot_n++; if (bad !== 0) $display("FAIL tie_read_data bad reads got %0d exp 0", bad); else pass_n++;
    endtask

    task automatic test_random;
        for (int t = 0; t < 30; t++) begin
            int k = int'($urandom_range(0, 1)), lat, ens;
            bit wr = 1'($urandom_range(0, 1));
            logic err, clr; logic [DW-1:0] d, v = {$urandom, $urandom};
            logic [SW-1:0] s = SW'($urandom_range(0, 255));
            logic [RANGE-1:0] sa;
            logic [AW-1:0] a;
            case ($urandom_range(0, 3))
                0:       a = START - AW'(8 * $urandom_range(1, 4));
                1:       a = START + 32'h100 + AW'($urandom_range(0, 64));
                default: a = START + AW'($urandom_range(0, 255));
            endcase
            if (wr) begin
                do_write(k, a, v, s, lat, ens, err, clr, sa);
                tot_n++; if (lat !== 1) $display("FAIL rnd%0d_wr_lat got %0d exp 1", t, lat); else pass_n++;
            end else begin
                do_read(k, a, lat, ens, err, clr, d);
                tot_n++; if (lat !== (k ? 4 : 2)) $display("FAIL rnd%0d_rd_lat got %0d exp %0d", t, lat, k ? 4 : 2); else pass_n++;
                tot_n++; if (d !== exp_rd(k, a)) $display("FAIL rnd%0d_rd_data addr %h got %h exp %h", t, a, d, exp_rd(k, a)); else pass_n++;
            end
            tot_n++;
            if ({ens, err, clr} !== {32'(in_win(a)), !in_win(a), 1'b0})
                $display("FAIL rnd%0d_en_err_clr addr %h got %0d/%b/%b exp %0d/%b/0", t, a, ens, err, clr, in_win(a), !in_win(a));
            else pass_n++;
        end
    endtask

    task automatic test_reset_mid;
        int lat = -1;
        logic [DW-1:0] d = 'x;
        @(negedge clk);
        r_req[1] = 1'b1; r_addr[1] = 32'h1000_0008;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        tot_n++;
        if ({w_ack[1], r_ack[1], w_err[1], r_err[1], en[1], we[1], r_data[1], saddr[1], swdata[1], swstrb[1]} !== '0)
            $display("FAIL mid_reset_outputs got %h exp 0",
                     {w_ack[1], r_ack[1], w_err[1], r_err[1], en[1], we[1], r_data[1], saddr[1], swdata[1], swstrb[1]});
        else pass_n++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 20 && lat < 0; i++) begin
            @(negedge clk);
            if (r_ack[1]) begin lat = i; d = r_data[1]; end
        end
        r_req[1] = 1'b0;
        tot_n++; if (lat !== 4) $display("FAIL mid_reset_reissue_lat got %0d exp 4", lat); else pass_n++;
        tot_n++; if (d !== ref_mem[1][1]) $display("FAIL mid_reset_reissue_data got %h exp %h", d, ref_mem[1][1]); else pass_n++;
        @(negedge clk);
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            w_req[k] = 1'b0; r_req[k] = 1'b0; w_addr[k] = '0; r_addr[k] = '0;
            w_data[k] = '0; w_strb[k] = '0;
        end
        test_reset;
        test_fill;
        test_single_write;
        test_readback;
        test_oob;
        test_strobe;
        test_early_drop;
        test_tie;
        test_random;
        test_reset_mid;
        $display("%0d/%0d checks passed", pass_n, tot_n);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout: %0d/%0d checks passed", pass_n, tot_n);
        $fatal(1);
    end
endmodule

// File: doc/axil_mem_arbiter.md
# axil_mem_arbiter

Shares one single-port synchronous SRAM between the independent write and read request channels of the AXI-lite slave's memory-side interface (`mem_w_*` / `mem_r_*`). It arbitrates round-robin between the two channels and translates byte addresses into SRAM word indices. It checks each address against the mapped window, drives the SRAM for exactly one access cycle per transaction, and returns level-held acks with registered read data and an error flag.

## Interface
Parameters:
- ADDR_W, 32, request address width
- DATA_W, 64, data width; multiple of 8
- MEM_ADDR_START, 'h10000000, byte base address of the SRAM window
- MEM_ADDR_RANGE, 5, log2 of SRAM depth in words; depth = 2**MEM_ADDR_RANGE
- RD_LAT, 1, SRAM read latency in cycles, legal 1..4

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset; one clock; reset is asynchronous and active-low
- mem_w_req  in  1  write request, level, held until ack seen
- mem_w_ack  out  1  write done, level
- mem_w_err  out  1  write address out of window, valid while mem_w_ack=1
- mem_w_addr  in  ADDR_W  write byte address
- mem_w_data  in  DATA_W  write data
- mem_w_strb  in  DATA_W/8  byte enables
- mem_r_req  in  1  read request, level
- mem_r_ack  out  1  read data valid, level
- mem_r_err  out  1  read address out of window, valid while mem_r_ack=1
- mem_r_addr  in  ADDR_W  read byte address
- mem_r_data  out  DATA_W  registered read data
- sram_en  out  1  access strobe, one cycle per transaction
- sram_we  out  1  1=write, 0=read; qualified by sram_en
- sram_addr  out  MEM_ADDR_RANGE  word index
- sram_wdata  out  DATA_W  write data
- sram_wstrb  out  DATA_W/8  byte write enables
- sram_rdata  in  DATA_W  SRAM read data, valid RD_LAT cycles after the en cycle

## Operation
- States: IDLE, WR, RD, RD_WAIT, W_HOLD, R_HOLD. Internal `last_gnt` bit (0=write, 1=read).
- IDLE: only mem_w_req -> WR; only mem_r_req -> RD; both -> the channel not in `last_gnt`. The chosen channel's address, data and strobe are latched. `last_gnt` is updated on each grant.
- Address: offset = addr - MEM_ADDR_START, unsigned ADDR_W arithmetic. In window iff addr >= MEM_ADDR_START and offset >> log2(DATA_W/8) < 2**MEM_ADDR_RANGE. sram_addr = offset[log2(DATA_W/8) +: MEM_ADDR_RANGE]. Low byte-offset bits are ignored, so misaligned addresses access the containing word.
- WR: sram_en=1, sram_we=1 for one cycle; strobe is passed through unchanged, including all-zero. Out of window: sram_en is suppressed and the err flag is latched to 1. Next state W_HOLD.
- RD: sram_en=1, sram_we=0 for one cycle, suppressed if out of window. Next state RD_WAIT with a counter loaded to RD_LAT-1.
- RD_WAIT: counts down; at 0, mem_r_data <= sram_rdata (0 if out of window). Next state R_HOLD.
- W_HOLD / R_HOLD: ack=1, err stable, mem_r_data stable. When the channel's req is sampled low, go to IDLE; ack and err clear at that edge.
- A pending request on the other channel waits; it is never dropped. After any HOLD, IDLE re-arbitrates in the same cycle.
- Req dropped before ack (protocol violation): the transaction still completes. Ack asserts for one cycle in HOLD, then the arbiter returns to IDLE.
- sram_en is 0 in every state except an in-window WR/RD cycle. sram_wdata/sram_wstrb/sram_addr hold their last latched values.

## Timing
- Reset values: mem_w_ack=0, mem_r_ack=0, mem_w_err=0, mem_r_err=0, mem_r_data=0, sram_en=0, sram_we=0, sram_addr=0, sram_wdata=0, sram_wstrb=0, state=IDLE, last_gnt=1 (write wins the first tie).
- Reset mid-transaction: immediate return to IDLE with all outputs at reset values. An in-flight SRAM access is abandoned; SRAM contents are outside scope.
- Write: req sampled at edge 0 -> WR cycle -> ack high after edge 1.
- Read: req sampled at edge 0 -> RD cycle -> ack high after edge 1+RD_LAT. Out-of-window transactions have the same latency.
- Ack falls after the first edge at which req=0 is sampled. Minimum IDLE-to-IDLE is 3 cycles for a write and 3+RD_LAT for a read, assuming req drops in the first ack cycle.
- At most one SRAM access is in flight; write and read never overlap.

## Test plan
- Single write: addr 'h10000008, data 'hDEAD_BEEF_0123_4567, strb 'hFF -> one sram_en/we pulse with sram_addr=1; mem_w_ack after edge 1, err=0; ack clears one edge after req drops.
- Read-back with RD_LAT=1 and RD_LAT=3: read 'h10000008 -> mem_r_data='hDEAD_BEEF_0123_4567, ack after edge 2 / edge 4.
- Simultaneous reqs from reset -> write served first, read second. Repeat with both reqs held -> grants alternate W, R, W, R.
- Out of window: write 'h0FFFFFF8 and read 'h10000100 (depth 32) -> no sram_en; err=1 with ack; read data 0.
- Partial strobe 'h0F to word 2, then read -> only the low 4 bytes change; misaligned read 'h10000013 returns word 2.
- Assert aresetn=0 during RD_WAIT (RD_LAT=3) -> acks 0 and sram_en 0 immediately. After release, a pending read reissues cleanly with correct data.
